// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// dmem_arbiter_if
// Bundles the CPU request port, the debug/loader request port, the data
// memory pins and the busy flag of the data-memory arbiter.
//   slave  : arbiter view (requests and mem_rdata in; acks, read data,
//            stall, memory pins and busy out).
//   master : requester/memory view, the mirror image of slave.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // CPU MEM-stage port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // Debug/loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  // Data memory pins
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dbg_ack, dbg_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dbg_ack, dbg_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
// Arbitrates the single data memory between the CPU MEM stage and the
// debug/loader port. One request is latched at a time, the memory pins are
// driven for MEM_LAT cycles, then the owner gets a one-cycle ack with its
// registered read data. The CPU normally wins; a starvation counter and a
// debug burst lock bound how long the debug port waits.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : dmem_arbiter_if.slave (CPU port, debug port, memory pins, busy)
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_arbiter_if.slave   bus
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = debug owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              lock_q, lock_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] drd_q, drd_d;

  logic              grant_cpu, grant_dbg;
  logic              ack_cpu, ack_dbg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      starve_q <= '0;
      lock_q   <= 1'b0;
      crd_q    <= '0;
      drd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      crd_q    <= crd_d;
      drd_q    <= drd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    lock_d    = lock_q;
    crd_d     = crd_q;
    drd_d     = drd_q;
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A held lock beats the CPU; otherwise the CPU wins until debug has
        // watched STARVE_MAX consecutive CPU grants.
        if (lock_q && bus.dbg_req) begin
          grant_dbg = 1'b1;
        end else if (bus.cpu_req && (starve_q < SC_W'(STARVE_MAX)) && !lock_q) begin
          grant_cpu = 1'b1;
        end else if (bus.dbg_req) begin
          grant_dbg = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end

        // Nobody waiting on the debug side: forget starvation and the lock.
        if (!bus.dbg_req) begin
          starve_d = '0;
          lock_d   = 1'b0;
        end

        if (grant_cpu) begin
          owner_d = 1'b0;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          if (bus.dbg_req && (starve_q < SC_W'(STARVE_MAX))) begin
            starve_d = starve_q + SC_W'(1);
          end
        end

        if (grant_dbg) begin
          owner_d  = 1'b1;
          we_d     = bus.dbg_we;
          addr_d   = bus.dbg_addr;
          wdata_d  = bus.dbg_wdata;
          starve_d = '0;
          lock_d   = bus.dbg_lock;
        end

        if (grant_cpu || grant_dbg) begin
          lat_d   = LAT_W'(MEM_LAT - 1);
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (lat_q == '0) begin
          // Memory data is valid on the last held cycle; only reads capture.
          if (!we_q) begin
            if (owner_q) begin
              drd_d = bus.mem_rdata;
            end else begin
              crd_d = bus.mem_rdata;
            end
          end
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from registered state so an asynchronous reset
  // drops mem_we at once, mid-access.
  assign ack_cpu = (state_q == S_DONE) && !owner_q;
  assign ack_dbg = (state_q == S_DONE) &&  owner_q;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = (state_q == S_ACCESS) && !we_q;
  // A write pulses only on the final held cycle so exactly one write lands.
  assign bus.mem_we    = (state_q == S_ACCESS) && we_q && (lat_q == '0);

  assign bus.cpu_ack   = ack_cpu;
  assign bus.dbg_ack   = ack_dbg;
  assign bus.cpu_rdata = crd_q;
  assign bus.dbg_rdata = drd_q;
  assign bus.cpu_stall = bus.cpu_req & ~ack_cpu;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
